// File: rtl/pwm_sched_pkg.sv
// Shared types and defaults for the PWM compare-update scheduler.
package pwm_sched_pkg;

    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_FAULT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/pwm_slew_step.sv
// Per-phase clamp and slew-limited step of one compare value toward its target.
module pwm_slew_step
    import pwm_sched_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_STEP = 64
) (
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] cur,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] step,
    output logic [CNT_W-1:0] target_clamp,
    output logic [CNT_W-1:0] duty_clamp
);

    localparam logic [CNT_W-1:0] MAX_STEP_C = CNT_W'(MAX_STEP);

    logic [CNT_W-1:0] delta_s;

    // Clamp both the stored and the incoming target to the live period, then slew
    always_comb begin
        target_clamp = (target > period) ? period : target;
        duty_clamp   = (duty > period) ? period : duty;
        if (target_clamp > cur) begin
            delta_s = target_clamp - cur;
            step    = cur + ((delta_s > MAX_STEP_C) ? MAX_STEP_C : delta_s);
        end else begin
            delta_s = cur - target_clamp;
            step    = cur - ((delta_s > MAX_STEP_C) ? MAX_STEP_C : delta_s);
        end
    end

endmodule

// File: rtl/pwm_update_scheduler.sv
// Slew-limited, period-synchronous compare scheduler for a 3-phase PWM with fault override.
module pwm_update_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_STEP = 64
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [CNT_W-1:0]   period,
    input  logic               period_sync,
    input  logic               ctrl_valid,
    output logic               ctrl_ready,
    input  logic [3*CNT_W-1:0] ctrl_duty,
    input  logic               flt_req,
    input  logic               flt_clr,
    output logic [3*CNT_W-1:0] cmp_out,
    output logic               cmp_load,
    output logic [1:0]         state,
    output logic [7:0]         ovr_cnt
);

    logic [2:0][CNT_W-1:0] cmp_r, tgt_r, cmp_n, tgt_n;
    logic [2:0][CNT_W-1:0] step_s, tclamp_s, dclamp_s;
    sched_state_e          state_r, state_n;
    logic                  load_r, load_n;
    logic                  ready_r, ready_n;
    logic [7:0]            ovr_r, ovr_n;
    logic                  accept_s;
    logic                  diff_s;

    for (genvar g = 0; g < 3; g++) begin : g_phase
        pwm_slew_step #(
            .CNT_W    (CNT_W),
            .MAX_STEP (MAX_STEP)
        ) u_step (
            .period       (period),
            .cur          (cmp_r[g]),
            .target       (tgt_r[g]),
            .duty         (ctrl_duty[g*CNT_W +: CNT_W]),
            .step         (step_s[g]),
            .target_clamp (tclamp_s[g]),
            .duty_clamp   (dclamp_s[g])
        );
    end

    assign accept_s   = ctrl_valid & ready_r;
    assign cmp_out    = cmp_r;
    assign cmp_load   = load_r;
    assign ctrl_ready = ready_r;
    assign state      = state_r;
    assign ovr_cnt    = ovr_r;

    // Next-state logic: fault override, sync stepping, handshake and overwrite counting
    always_comb begin
        cmp_n   = cmp_r;
        tgt_n   = tgt_r;
        load_n  = 1'b0;
        ready_n = ready_r;
        ovr_n   = ovr_r;
        state_n = state_r;
        diff_s  = 1'b0;
        case (state_r)
            ST_FAULT: begin
                if (!flt_req && flt_clr) begin
                    state_n = ST_IDLE;
                    ready_n = 1'b1;
                end else begin
                    state_n = ST_FAULT;
                    ready_n = 1'b0;
                end
            end
            ST_IDLE, ST_RAMP: begin
                if (flt_req) begin
                    cmp_n   = {(3*CNT_W){1'b0}};
                    tgt_n   = {(3*CNT_W){1'b0}};
                    load_n  = 1'b1;
                    ready_n = 1'b0;
                    state_n = ST_FAULT;
                end else begin
                    // The step uses the old target; an accept in the same cycle lands afterwards
                    if (period_sync) begin
                        cmp_n = step_s;
                        tgt_n = tclamp_s;
                    end else begin
                        cmp_n = cmp_r;
                    end
                    if (accept_s) begin
                        tgt_n = dclamp_s;
                        if ((state_r == ST_RAMP) && (ovr_r != 8'hFF)) begin
                            ovr_n = ovr_r + 8'd1;
                        end else begin
                            ovr_n = ovr_r;
                        end
                    end else begin
                        ovr_n = ovr_r;
                    end
                    load_n = (cmp_n != cmp_r);
                    for (int i = 0; i < 3; i++) begin
                        diff_s = diff_s | (cmp_n[i] != tgt_n[i]);
                    end
                    state_n = diff_s ? ST_RAMP : ST_IDLE;
                    ready_n = 1'b1;
                end
            end
            default: begin
                cmp_n   = {(3*CNT_W){1'b0}};
                tgt_n   = {(3*CNT_W){1'b0}};
                load_n  = 1'b1;
                ready_n = 1'b0;
                state_n = ST_FAULT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cmp_r   <= {(3*CNT_W){1'b0}};
            tgt_r   <= {(3*CNT_W){1'b0}};
            load_r  <= 1'b0;
            ready_r <= 1'b1;
            ovr_r   <= 8'd0;
            state_r <= ST_IDLE;
        end else begin
            cmp_r   <= cmp_n;
            tgt_r   <= tgt_n;
            load_r  <= load_n;
            ready_r <= ready_n;
            ovr_r   <= ovr_n;
            state_r <= state_n;
        end
    end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Directed self-checking bench for pwm_update_scheduler (period=1000, MAX_STEP=64).
module tb_pwm_update_scheduler;

    localparam int CNT_W = 16;

    logic               ACLK = 1'b0;
    logic               ARESET;
    logic [CNT_W-1:0]   period;
    logic               period_sync;
    logic               ctrl_valid;
    logic               ctrl_ready;
    logic [3*CNT_W-1:0] ctrl_duty;
    logic               flt_req;
    logic               flt_clr;
    logic [3*CNT_W-1:0] cmp_out;
    logic               cmp_load;
    logic [1:0]         state;
    logic [7:0]         ovr_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pwm_update_scheduler #(.CNT_W(CNT_W), .MAX_STEP(64)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .period      (period),
        .period_sync (period_sync),
        .ctrl_valid  (ctrl_valid),
        .ctrl_ready  (ctrl_ready),
        .ctrl_duty   (ctrl_duty),
        .flt_req     (flt_req),
        .flt_clr     (flt_clr),
        .cmp_out     (cmp_out),
        .cmp_load    (cmp_load),
        .state       (state),
        .ovr_cnt     (ovr_cnt)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3*CNT_W-1:0] pack3(input int a, input int b, input int c);
        return {c[CNT_W-1:0], b[CNT_W-1:0], a[CNT_W-1:0]};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_sync();
        period_sync = 1'b1;
        tick();
        period_sync = 1'b0;
    endtask

    task automatic do_accept(input int a, input int b, input int c);
        ctrl_valid = 1'b1;
        ctrl_duty  = pack3(a, b, c);
        tick();
        ctrl_valid = 1'b0;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
    endtask

    int ea[5] = '{64, 100, 100, 100, 100};
    int eb[5] = '{64, 128, 192, 200, 200};
    int ec[5] = '{64, 128, 192, 256, 300};

    initial begin
        period      = 16'd1000;
        period_sync = 1'b0;
        ctrl_valid  = 1'b0;
        ctrl_duty   = '0;
        flt_req     = 1'b0;
        flt_clr     = 1'b0;
        do_reset();

        check_val("rst_cmp", 64'(cmp_out), 64'(pack3(0, 0, 0)));
        check_val("rst_load", 64'(cmp_load), 64'd0);
        check_val("rst_ready", 64'(ctrl_ready), 64'd1);
        check_val("rst_state", 64'(state), 64'd0);
        check_val("rst_ovr", 64'(ovr_cnt), 64'd0);

        // ramp
        do_accept(100, 200, 300);
        check_val("ramp_state", 64'(state), 64'd1);
        check_val("ramp_noload", 64'(cmp_load), 64'd0);
        for (int i = 0; i < 5; i++) begin
            do_sync();
            check_val($sformatf("ramp_cmp%0d", i), 64'(cmp_out), 64'(pack3(ea[i], eb[i], ec[i])));
            check_val($sformatf("ramp_load%0d", i), 64'(cmp_load), 64'd1);
            tick();
            check_val($sformatf("ramp_drop%0d", i), 64'(cmp_load), 64'd0);
        end
        check_val("ramp_idle", 64'(state), 64'd0);
        do_sync();
        check_val("nochange_load", 64'(cmp_load), 64'd0);
        check_val("nochange_cmp", 64'(cmp_out), 64'(pack3(100, 200, 300)));

        // clamp above period
        do_accept(1200, 0, 0);
        check_val("clamp_ovr", 64'(ovr_cnt), 64'd0);
        for (int i = 0; i < 16; i++) begin
            do_sync();
        end
        check_val("clamp_cmp", 64'(cmp_out), 64'(pack3(1000, 0, 0)));
        check_val("clamp_state", 64'(state), 64'd0);

        // overwrite
        do_reset();
        do_accept(500, 500, 500);
        do_sync();
        check_val("ovw_step", 64'(cmp_out), 64'(pack3(64, 64, 64)));
        do_accept(0, 0, 0);
        check_val("ovw_cnt", 64'(ovr_cnt), 64'd1);
        do_sync();
        check_val("ovw_cmp", 64'(cmp_out), 64'(pack3(0, 0, 0)));
        check_val("ovw_state", 64'(state), 64'd0);

        // simultaneous accept and sync
        do_reset();
        check_val("rst2_ovr", 64'(ovr_cnt), 64'd0);
        do_accept(500, 500, 500);
        do_sync();
        ctrl_valid  = 1'b1;
        ctrl_duty   = pack3(0, 0, 0);
        period_sync = 1'b1;
        tick();
        ctrl_valid  = 1'b0;
        period_sync = 1'b0;
        check_val("sim_cmp", 64'(cmp_out), 64'(pack3(128, 128, 128)));
        check_val("sim_ovr", 64'(ovr_cnt), 64'd1);
        do_sync();
        check_val("sim_back1", 64'(cmp_out), 64'(pack3(64, 64, 64)));
        do_sync();
        check_val("sim_back0", 64'(cmp_out), 64'(pack3(0, 0, 0)));
        check_val("sim_state", 64'(state), 64'd0);

        // fault mid-ramp
        do_accept(500, 500, 500);
        do_sync();
        flt_req = 1'b1;
        tick();
        check_val("flt_cmp", 64'(cmp_out), 64'(pack3(0, 0, 0)));
        check_val("flt_load", 64'(cmp_load), 64'd1);
        check_val("flt_ready", 64'(ctrl_ready), 64'd0);
        check_val("flt_state", 64'(state), 64'd2);
        ctrl_valid  = 1'b1;
        ctrl_duty   = pack3(700, 700, 700);
        period_sync = 1'b1;
        tick();
        ctrl_valid  = 1'b0;
        period_sync = 1'b0;
        check_val("flt_oneload", 64'(cmp_load), 64'd0);
        check_val("flt_ignore", 64'(cmp_out), 64'(pack3(0, 0, 0)));
        check_val("flt_ovr", 64'(ovr_cnt), 64'd1);
        flt_clr = 1'b1;
        tick();
        flt_clr = 1'b0;
        check_val("flt_clr_held", 64'(state), 64'd2);
        flt_req = 1'b0;
        tick();
        check_val("flt_wait_clr", 64'(state), 64'd2);
        flt_clr = 1'b1;
        tick();
        flt_clr = 1'b0;
        check_val("flt_exit", 64'(state), 64'd0);
        check_val("flt_exit_rdy", 64'(ctrl_ready), 64'd1);
        do_sync();
        check_val("flt_tgt_zero", 64'(cmp_load), 64'd0);

        // period reduced below stored target
        do_accept(900, 0, 0);
        do_sync();
        period = 16'd200;
        do_sync();
        check_val("red_step", 64'(cmp_out), 64'(pack3(128, 0, 0)));
        do_sync();
        do_sync();
        check_val("red_cmp", 64'(cmp_out), 64'(pack3(200, 0, 0)));
        check_val("red_state", 64'(state), 64'd0);
        period = 16'd1000;

        // reset mid-ramp discards target
        do_accept(500, 500, 500);
        do_sync();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        check_val("rmid_load", 64'(cmp_load), 64'd0);
        check_val("rmid_cmp", 64'(cmp_out), 64'(pack3(0, 0, 0)));
        check_val("rmid_state", 64'(state), 64'd0);
        do_sync();
        check_val("rmid_nostep", 64'(cmp_load), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_update_scheduler.md
PWM_UPDATE_SCHEDULER -- requirements
Module: pwm_update_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of PWM counter, period and compare values.
REQ-002 SHALL have parameter MAX_STEP, default 64, max compare change per phase per PWM period.
REQ-003 SHALL have port ACLK  in  1  single clock for all logic.
REQ-004 SHALL have port ARESET  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port period  in  CNT_W  current PWM period register value, used as duty ceiling.
REQ-006 SHALL have port period_sync  in  1  one-cycle pulse from PWM generator at counter wrap.
REQ-007 SHALL have port ctrl_valid  in  1  control loop presents new duty set.
REQ-008 SHALL have port ctrl_ready  out  1  scheduler accepts duty set.
REQ-009 SHALL have port ctrl_duty  in  3*CNT_W  target compare, phase A in LSBs, then B, then C.
REQ-010 SHALL have port flt_req  in  1  level; fault/brake handler demands outputs off.
REQ-011 SHALL have port flt_clr  in  1  one-cycle pulse; release from fault.
REQ-012 SHALL have port cmp_out  out  3*CNT_W  compare values driven to PWM generator shadow registers.
REQ-013 SHALL have port cmp_load  out  1  one-cycle pulse; PWM generator latches cmp_out.
REQ-014 SHALL have port state  out  2  IDLE=0, RAMP=1, FAULT=2.
REQ-015 SHALL have port ovr_cnt  out  8  saturating count of overwritten, unreached targets.

Function
REQ-016 SHALL accept a duty set when ctrl_valid and ctrl_ready are both 1 in the same cycle.
REQ-017 SHALL drive ctrl_ready=1 in IDLE and RAMP, 0 in FAULT.
REQ-018 SHALL store each accepted phase value clamped to min(ctrl_duty_x, period) as that phase's target.
REQ-019 SHALL, on period_sync outside FAULT, step each phase: cmp += sign(target-cmp) * min(|target-cmp|, MAX_STEP).
REQ-020 SHALL update cmp_out and pulse cmp_load in the cycle after period_sync only if at least one phase changed.
REQ-021 SHALL never change cmp_out except at that post-sync cycle or on fault entry.
REQ-022 SHALL be in RAMP whenever any cmp differs from its target; IDLE when all equal.
REQ-023 SHALL, on acceptance while in RAMP, overwrite targets and increment ovr_cnt, saturating at 255.
REQ-024 SHALL, on simultaneous acceptance and period_sync, step toward the old target; the new target applies from the next sync.
REQ-025 SHALL, when flt_req=1 in any state, enter FAULT next cycle with cmp_out=0, targets=0 and one cmp_load pulse, without waiting for sync.
REQ-026 SHALL ignore period_sync and ctrl_valid while in FAULT.
REQ-027 SHALL leave FAULT for IDLE only on flt_clr=1 with flt_req=0; flt_clr with flt_req=1 SHALL be ignored.
REQ-028 SHALL re-evaluate the clamp against the current period at each step; a target above a reduced period SHALL be clamped at that step.

Reset
REQ-029 SHALL, with ARESET=1 at a clock edge, set cmp_out=0, targets=0, cmp_load=0, ctrl_ready=1 (from the first cycle after reset), state=IDLE, ovr_cnt=0.
REQ-030 SHALL, on reset mid-ramp or in FAULT, discard the target; no cmp_load pulse is issued on reset.

Structure
REQ-031 SHALL take the state enum, encoding constants and default CNT_W from shared package pwm_sched_pkg.
REQ-032 SHALL implement the per-phase clamp/step arithmetic in sub-module pwm_slew_step, instantiated three times.
REQ-033 SHALL contain the FSM, handshake, ovr_cnt and fault handling in the top level only.

Verification (period=1000, MAX_STEP=64)
REQ-034 SHALL check reset: cmp_out=0, cmp_load=0, ctrl_ready=1, state=IDLE, ovr_cnt=0.
REQ-035 SHALL check ramp: accept (100,200,300); successive syncs give A 64,100; B 64,128,192,200; C 64,128,192,256,300; state=IDLE after the 5th load.
REQ-036 SHALL check clamp: accept (1200,0,0) and apply 16 syncs; A settles at exactly 1000.
REQ-037 SHALL check overwrite: accept (500,500,500), apply 1 sync, accept (0,0,0) -> ovr_cnt=1; the next sync gives cmp=0.
REQ-038 SHALL check fault mid-ramp: flt_req=1 -> next cycle cmp=0, one cmp_load, ctrl_ready=0; flt_clr while flt_req=1 keeps FAULT; after flt_req=0 and flt_clr -> IDLE.
REQ-039 SHALL check simultaneous accept and sync: cmp is at 64 and the accept is (0,0,0) -> cmp steps to 128 first, then returns toward 0.
